// File: rtl/clock_pkg.sv
// Shared definitions for the time_keeper slice: mode encodings, field limits
// and widths, plus the 12 h display decode.
package clock_pkg;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  // 24 h count -> 1..12 display value
  function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
    if (h == HOUR_W'(0))       return HOUR_W'(12);
    else if (h > HOUR_W'(12))  return h - HOUR_W'(12);
    else                       return h;
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Bus between the tick/button source (master) and time_keeper (slave).
//   tick_in/btn_mode/btn_inc : master -> slave
//   hours/minutes/seconds/mode/sec_pulse/day_pulse (+pm) : slave -> master
// pm exists only when TIME_KEEPER_12H_EN is defined.
interface time_keeper_if;
  import clock_pkg::*;

  logic              tick_in;
  logic              btn_mode;
  logic              btn_inc;
  logic [HOUR_W-1:0] hours;
  logic [MIN_W-1:0]  minutes;
  logic [SEC_W-1:0]  seconds;
  logic [1:0]        mode;
  logic              sec_pulse;
  logic              day_pulse;
`ifdef TIME_KEEPER_12H_EN
  logic              pm;
`endif

  modport master (
    output tick_in, btn_mode, btn_inc,
    input  hours, minutes, seconds, mode, sec_pulse, day_pulse
`ifdef TIME_KEEPER_12H_EN
    , input pm
`endif
  );

  modport slave (
    input  tick_in, btn_mode, btn_inc,
    output hours, minutes, seconds, mode, sec_pulse, day_pulse
`ifdef TIME_KEEPER_12H_EN
    , output pm
`endif
  );
endinterface

// File: rtl/time_keeper_mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear.
//   clk, rst  : clock, synchronous active-high reset (loads INIT)
//   inc_i     : advance by one, wrapping MAX -> 0
//   clear_i   : force to 0 (wins over inc_i)
//   value_o   : registered count
//   carry_c   : combinational wrap flag (inc_i while at MAX), feeds the next stage
module mod_counter #(
  parameter int unsigned MAX  = 59,
  parameter int unsigned W    = 6,
  parameter int unsigned INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clear_i,
  output logic [W-1:0] value_o,
  output logic         carry_c
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  assign carry_c = inc_i && (value_q == W'(MAX));

  always_comb begin
    value_d = value_q;
    if (clear_i)      value_d = '0;
    else if (carry_c) value_d = '0;
    else if (inc_i)   value_d = value_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= W'(INIT);
    else     value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/time_keeper.sv
// 24 h hh:mm:ss keeper driven by the rising edges of a clk-synchronous 1 Hz
// tick, with a RUN -> SET_HOUR -> SET_MIN button FSM for setting the time.
//   clk, rst : clock, synchronous active-high reset
//   bus      : time_keeper_if.slave (tick/buttons in, time/mode/pulses out)
// Optional macro TIME_KEEPER_12H_EN: hours shown as 1..12 and pm is driven.
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned INIT_HOUR = 0,
  parameter int unsigned INIT_MIN  = 0,
  parameter int unsigned INIT_SEC  = 0
) (
  input  logic          clk,
  input  logic          rst,
  time_keeper_if.slave  bus
);

  mode_e             state_q, state_d;
  logic              tick_q;
  logic              sec_pulse_q, day_pulse_q;
  logic              rise_c, run_c, set_hour_c, set_min_c;
  logic              sec_inc_c, sec_clr_c, min_inc_c, hr_inc_c;
  logic              sec_carry_c, min_carry_c, hr_carry_c;
  logic [SEC_W-1:0]  sec_v;
  logic [MIN_W-1:0]  min_v;
  logic [HOUR_W-1:0] hr_v;

  // Tick is already in the clk domain; a single flop is enough for edge detect.
  assign rise_c     = bus.tick_in & ~tick_q;
  assign run_c      = (state_q == MODE_RUN);
  assign set_hour_c = (state_q == MODE_SET_HOUR);
  assign set_min_c  = (state_q == MODE_SET_MIN);

  // A mode press in the same cycle drops both the tick and any increment.
  assign sec_inc_c = run_c & rise_c & ~bus.btn_mode;
  assign sec_clr_c = set_min_c & bus.btn_mode;
  assign min_inc_c = (run_c & sec_carry_c) | (set_min_c & bus.btn_inc & ~bus.btn_mode);
  assign hr_inc_c  = (run_c & min_carry_c) | (set_hour_c & bus.btn_inc & ~bus.btn_mode);

  // Mode FSM next state
  always_comb begin
    state_d = state_q;
    if (bus.btn_mode) begin
      case (state_q)
        MODE_RUN:      state_d = MODE_SET_HOUR;
        MODE_SET_HOUR: state_d = MODE_SET_MIN;
        MODE_SET_MIN:  state_d = MODE_RUN;
        default:       state_d = MODE_RUN;
      endcase
    end
  end

  // State, edge-detect and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MODE_RUN;
      tick_q      <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= bus.tick_in;
      sec_pulse_q <= sec_inc_c;
      // In RUN the hour counter only wraps when seconds and minutes wrap too.
      day_pulse_q <= run_c & hr_carry_c;
    end
  end

  mod_counter #(.MAX(SEC_MAX), .W(SEC_W), .INIT(INIT_SEC)) u_sec (
    .clk(clk), .rst(rst), .inc_i(sec_inc_c), .clear_i(sec_clr_c),
    .value_o(sec_v), .carry_c(sec_carry_c)
  );

  mod_counter #(.MAX(MIN_MAX), .W(MIN_W), .INIT(INIT_MIN)) u_min (
    .clk(clk), .rst(rst), .inc_i(min_inc_c), .clear_i(1'b0),
    .value_o(min_v), .carry_c(min_carry_c)
  );

  mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W), .INIT(INIT_HOUR)) u_hr (
    .clk(clk), .rst(rst), .inc_i(hr_inc_c), .clear_i(1'b0),
    .value_o(hr_v), .carry_c(hr_carry_c)
  );

  assign bus.minutes   = min_v;
  assign bus.seconds   = sec_v;
  assign bus.mode      = state_q;
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.day_pulse = day_pulse_q;

`ifdef TIME_KEEPER_12H_EN
  // Pure decode of the registered 24 h count
  assign bus.hours = to_12h(hr_v);
  assign bus.pm    = (hr_v >= HOUR_W'(12));
`else
  assign bus.hours = hr_v;
`endif

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  time_keeper_if ifa ();
  time_keeper_if ifb ();
  time_keeper_if ifc ();

  time_keeper #(.INIT_HOUR(0),  .INIT_MIN(0),  .INIT_SEC(0))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
  time_keeper #(.INIT_HOUR(23), .INIT_MIN(59), .INIT_SEC(58)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  time_keeper #(.INIT_HOUR(10), .INIT_MIN(0),  .INIT_SEC(4))  dut_c (.clk(clk), .rst(rst), .bus(ifc));

`ifdef TIME_KEEPER_12H_EN
  `define TB_PM(i) i.pm
`else
  `define TB_PM(i) 1'b0
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input integer obs, input integer exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected hours output (and pm) for an internal 24 h value
  task automatic chk_hr(input string tag, input integer obs_h, input integer obs_pm, input int h24);
`ifdef TIME_KEEPER_12H_EN
    chk(tag, obs_h, (h24 % 12 == 0) ? 12 : h24 % 12);
    chk({tag, "_pm"}, obs_pm, (h24 >= 12) ? 1 : 0);
`else
    chk(tag, obs_h, h24);
    chk({tag, "_pm"}, obs_pm, 0);
`endif
  endtask

  initial begin
    ifa.tick_in = 0; ifa.btn_mode = 0; ifa.btn_inc = 0;
    ifb.tick_in = 0; ifb.btn_mode = 0; ifb.btn_inc = 0;
    ifc.tick_in = 0; ifc.btn_mode = 0; ifc.btn_inc = 0;

    // Reset state
    step(); step();
    chk_hr("a_rst_hr", ifa.hours, `TB_PM(ifa), 0);
    chk("a_rst_min", ifa.minutes, 0);
    chk("a_rst_sec", ifa.seconds, 0);
    chk("a_rst_mode", ifa.mode, 0);
    chk("a_rst_spulse", ifa.sec_pulse, 0);
    chk("a_rst_dpulse", ifa.day_pulse, 0);
    chk_hr("b_rst_hr", ifb.hours, `TB_PM(ifb), 23);
    chk("b_rst_min", ifb.minutes, 59);
    chk("b_rst_sec", ifb.seconds, 58);
    chk_hr("c_rst_hr", ifc.hours, `TB_PM(ifc), 10);
    chk("c_rst_sec", ifc.seconds, 4);
    rst = 0;

    // Test 1: tick toggling every 5 clk
    ifa.tick_in = 1; step();
    chk("t1_first_pulse", ifa.sec_pulse, 1);
    chk("t1_first_sec", ifa.seconds, 1);
    step();
    chk("t1_sec_2clk", ifa.seconds, 1);
    chk("t1_pulse_1clk", ifa.sec_pulse, 0);
    repeat (3) step();
    ifa.tick_in = 0; repeat (5) step();
    for (int p = 0; p < 2; p++) begin
      ifa.tick_in = 1; repeat (5) step();
      ifa.tick_in = 0; repeat (5) step();
    end
    chk("t1_sec_3", ifa.seconds, 3);
    chk("t1_min_0", ifa.minutes, 0);

    // Test 2: full-day rollover
    ifb.tick_in = 1; step();
    chk("t2_sec59", ifb.seconds, 59);
    chk("t2_dpulse_early", ifb.day_pulse, 0);
    ifb.tick_in = 0; step();
    ifb.tick_in = 1; step();
    chk_hr("t2_roll_hr", ifb.hours, `TB_PM(ifb), 0);
    chk("t2_roll_min", ifb.minutes, 0);
    chk("t2_roll_sec", ifb.seconds, 0);
    chk("t2_roll_spulse", ifb.sec_pulse, 1);
    chk("t2_roll_dpulse", ifb.day_pulse, 1);
    ifb.tick_in = 0; step();
    chk("t2_dpulse_1clk", ifb.day_pulse, 0);
    chk("t2_spulse_1clk", ifb.sec_pulse, 0);

    // Test 3: set hours then minutes on dut_a (00:00:03)
    ifa.btn_mode = 1; step(); ifa.btn_mode = 0;
    chk("t3_mode1", ifa.mode, 1);
    for (int k = 0; k < 22; k++) begin ifa.btn_inc = 1; step(); end
    ifa.btn_inc = 0;
    chk_hr("t3_hr22", ifa.hours, `TB_PM(ifa), 22);
    ifa.btn_inc = 1; step(); chk_hr("t3_hr23", ifa.hours, `TB_PM(ifa), 23);
    step(); chk_hr("t3_hr0", ifa.hours, `TB_PM(ifa), 0);
    step(); chk_hr("t3_hr1", ifa.hours, `TB_PM(ifa), 1);
    repeat (10) step(); chk_hr("t3_hr11", ifa.hours, `TB_PM(ifa), 11);
    step(); chk_hr("t3_hr12", ifa.hours, `TB_PM(ifa), 12);
    step(); chk_hr("t3_hr13", ifa.hours, `TB_PM(ifa), 13);
    repeat (12) step(); chk_hr("t3_hr1b", ifa.hours, `TB_PM(ifa), 1);
    ifa.btn_inc = 0;
    chk("t3_min_unset", ifa.minutes, 0);
    ifa.btn_mode = 1; step(); ifa.btn_mode = 0;
    chk("t3_mode2", ifa.mode, 2);
    for (int k = 0; k < 61; k++) begin ifa.btn_inc = 1; step(); end
    ifa.btn_inc = 0;
    chk("t3_min1", ifa.minutes, 1);
    chk_hr("t3_hr_nocarry", ifa.hours, `TB_PM(ifa), 1);
    chk("t3_sec_frozen", ifa.seconds, 3);

    // Test 4: ticks ignored in SET, leaving SET_MIN clears seconds
    ifa.tick_in = 1; step();
    chk("t4_set_spulse", ifa.sec_pulse, 0);
    chk("t4_set_sec", ifa.seconds, 3);
    ifa.tick_in = 0; step();
    ifa.btn_mode = 1; step(); ifa.btn_mode = 0;
    chk("t4_mode0", ifa.mode, 0);
    chk("t4_sec_clr", ifa.seconds, 0);
    chk("t4_min_kept", ifa.minutes, 1);
    ifa.tick_in = 1; step();
    chk("t4_run_sec", ifa.seconds, 1);
    chk("t4_run_spulse", ifa.sec_pulse, 1);
    ifa.tick_in = 0; step();
    ifa.btn_inc = 1; step(); ifa.btn_inc = 0;
    chk_hr("t4_inc_run_hr", ifa.hours, `TB_PM(ifa), 1);
    chk("t4_inc_run_min", ifa.minutes, 1);
    chk("t4_inc_run_sec", ifa.seconds, 1);

    // Test 5: simultaneous events on dut_c (10:00:04)
    ifc.tick_in = 1; step();
    chk("t5_sec5", ifc.seconds, 5);
    ifc.tick_in = 0; step();
    ifc.tick_in = 1; ifc.btn_mode = 1; step();
    ifc.tick_in = 0; ifc.btn_mode = 0;
    chk("t5_mode1", ifc.mode, 1);
    chk("t5_tick_lost", ifc.seconds, 5);
    chk("t5_no_spulse", ifc.sec_pulse, 0);
    step();
    ifc.btn_mode = 1; ifc.btn_inc = 1; step();
    ifc.btn_mode = 0; ifc.btn_inc = 0;
    chk("t5_mode2", ifc.mode, 2);
    chk_hr("t5_hr_kept", ifc.hours, `TB_PM(ifc), 10);
    ifc.btn_inc = 1; step(); ifc.btn_inc = 0;
    chk("t5_min1", ifc.minutes, 1);
    ifc.btn_mode = 1; ifc.btn_inc = 1; step();
    ifc.btn_mode = 0; ifc.btn_inc = 0;
    chk("t5_mode0", ifc.mode, 0);
    chk("t5_min_kept", ifc.minutes, 1);
    chk("t5_sec_clr", ifc.seconds, 0);

    // Test 6: reset mid-run overrides a pending rise; tick high at release rises
    ifb.tick_in = 1; rst = 1; step();
    chk_hr("t6_rst_hr", ifb.hours, `TB_PM(ifb), 23);
    chk("t6_rst_sec", ifb.seconds, 58);
    chk("t6_rst_spulse", ifb.sec_pulse, 0);
    chk("t6_rst_a_mode", ifa.mode, 0);
    rst = 0; step();
    chk("t6_rel_sec", ifb.seconds, 59);
    chk("t6_rel_spulse", ifb.sec_pulse, 1);
    ifb.tick_in = 0; step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
